parking_occupancy: RTL and testbench
====================================

Name: parking_occupancy

Overview:
- Consumes the `entrada`/`salida` car-event indications produced by the two-sensor detector (A/B barrier sensors).
- Maintains the parking-lot occupancy count against a fixed capacity and drives the free-space display digits.
- Controls the barrier with a timed open window.
- Sits between the detector and the display/barrier actuator in the parking top level.

Parameters:
- CAPACITY, 20, number of spaces; legal range 1..99.
- CNT_W, 7, width of the occupancy counter; must satisfy 2^CNT_W > CAPACITY.
- GATE_CYCLES, 50, clock cycles the barrier stays open after the last accepted event; must be ≥1.
- TMR_W, 6, width of the barrier timer; must satisfy 2^TMR_W ≥ GATE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- entrada  in  1  car-entered indication from detector; level, may stay high several cycles.
- salida  in  1  car-exited indication from detector; level, may stay high several cycles.
- count  out  CNT_W  cars currently inside.
- libres_dec  out  4  BCD tens digit of free spaces (CAPACITY − count).
- libres_uni  out  4  BCD units digit of free spaces.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- rechazo  out  1  one-cycle pulse: entry event arrived while full.
- error  out  1  sticky: exit event arrived while empty.
- barrera  out  1  1 = barrier open.

Behaviour:
- Reset (reset=0, asynchronous), all registered, values while reset is asserted:
  - count=0, empty=1, full=0.
  - libres_dec/libres_uni = BCD of CAPACITY.
  - rechazo=0, error=0, barrera=0, barrier FSM = CERRADA, timer=0.
  - Edge-detect history registers = 0.
- Reset release: history registers start at 0, so an input already high at release counts as one event on the first rising edge.
- Reset mid-operation: everything returns to reset values immediately, regardless of state or timer.
- Event detection:
  - `ev_in = entrada & ~entrada_q`, `ev_out = salida & ~salida_q`; `entrada_q`/`salida_q` are registered copies of the inputs.
  - An input held high N cycles produces exactly one event.
- Latency: all outputs update on the same rising edge at which the input is first sampled high (1 edge, 0 extra cycles).
- Count update, evaluated per edge in priority order:
  - ev_in & ev_out → count unchanged, no rechazo, no error; counts as an accepted event for the barrier.
  - ev_in & ~full → count+1, accepted.
  - ev_in & full → count unchanged, rechazo=1 for exactly one cycle, not accepted.
  - ev_out & ~empty → count−1, accepted.
  - ev_out & empty → count unchanged, error set to 1 and held until reset, not accepted.
  - count never exceeds CAPACITY and never wraps below 0.
- Flag outputs:
  - full and empty are registered and consistent with count in the same cycle.
  - libres_dec/libres_uni are registered together with count: (CAPACITY − next_count) / 10 and % 10. Digits are never above 9.
- Barrier FSM, states CERRADA and ABIERTA:
  - CERRADA + accepted event → ABIERTA, timer = GATE_CYCLES−1.
  - ABIERTA + accepted event → stay ABIERTA, timer reloaded to GATE_CYCLES−1 (window extends).
  - ABIERTA, no event, timer>0 → timer−1.
  - ABIERTA, no event, timer==0 → CERRADA.
  - barrera = (state == ABIERTA), registered. It is high for exactly GATE_CYCLES cycles after a single isolated accepted event.
  - Rejected events (rechazo, error case) do not open or extend the barrier.
- No combinational path from inputs to outputs.

Test Plan:
- Reset/idle: reset=0 then 1, CAPACITY=3 → count=0, empty=1, full=0, libres_dec=0, libres_uni=3, barrera=0, error=0.
- Three entrada pulses (each high 3 cycles, CAPACITY=3) → count steps 1, 2, 3, once per pulse. full=1 after the third; libres_uni=0.
- Fourth entrada pulse while full → count stays 3, rechazo high exactly 1 cycle, barrera unchanged.
- entrada and salida rising on the same edge at count=2 → count stays 2, barrera opens.
- salida pulse at count=0 → count stays 0, error=1 and remains 1 through later entries until reset=0.
- GATE_CYCLES=4:
  - One entry → barrera high for exactly 4 cycles.
  - Second entry on the 3rd open cycle → barrera stays high 4 more cycles from that edge.
  - reset=0 mid-window → barrera=0 immediately.

Source files
------------

// File: rtl/parking_occupancy_if.sv
// Event inputs from the car detector and the occupancy/display/barrier outputs
// of the parking occupancy block, bundled as one port.
interface parking_occupancy_if #(
    parameter int unsigned CNT_W = 7
);
    logic             entrada;
    logic             salida;
    logic [CNT_W-1:0] count;
    logic [3:0]       libres_dec;
    logic [3:0]       libres_uni;
    logic             full;
    logic             empty;
    logic             rechazo;
    logic             error;
    logic             barrera;

    modport master (
        output entrada, salida,
        input  count, libres_dec, libres_uni, full, empty, rechazo, error, barrera
    );

    modport slave (
        input  entrada, salida,
        output count, libres_dec, libres_uni, full, empty, rechazo, error, barrera
    );
endinterface

// File: rtl/parking_occupancy.sv
// Parking occupancy counter: edge-detects entry/exit events, tracks the count
// against CAPACITY, drives BCD free-space digits and a timed barrier window.
module parking_occupancy #(
    parameter int unsigned CAPACITY    = 20,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned GATE_CYCLES = 50,
    parameter int unsigned TMR_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    parking_occupancy_if.slave   bus
);

    typedef enum logic {CERRADA, ABIERTA} gate_state_e;

    logic             entrada_q, salida_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [3:0]       dec_q, dec_d;
    logic [3:0]       uni_q, uni_d;
    logic             rechazo_q, rechazo_d;
    logic             error_q, error_d;
    gate_state_e      state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic             ev_in, ev_out, accepted;
    logic [7:0]       free_d;

    assign ev_in  = bus.entrada & ~entrada_q;
    assign ev_out = bus.salida  & ~salida_q;

    always_comb begin
        count_d   = count_q;
        rechazo_d = 1'b0;
        error_d   = error_q;
        accepted  = 1'b0;
        if (ev_in && ev_out) begin
            accepted = 1'b1;
        end else if (ev_in) begin
            if (!full_q) begin
                count_d  = count_q + CNT_W'(1);
                accepted = 1'b1;
            end else begin
                rechazo_d = 1'b1;
            end
        end else if (ev_out) begin
            if (!empty_q) begin
                count_d  = count_q - CNT_W'(1);
                accepted = 1'b1;
            end else begin
                error_d = 1'b1;
            end
        end
        full_d  = (count_d == CNT_W'(CAPACITY));
        empty_d = (count_d == '0);
        // 8-bit arithmetic keeps the digit split valid for narrow CNT_W
        free_d  = 8'(CAPACITY) - 8'(count_d);
        dec_d   = 4'(free_d / 8'd10);
        uni_d   = 4'(free_d % 8'd10);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (accepted) begin
            state_d = ABIERTA;
            timer_d = TMR_W'(GATE_CYCLES - 1);
        end else if (state_q == ABIERTA) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TMR_W'(1);
            end else begin
                state_d = CERRADA;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entrada_q <= 1'b0;
            salida_q  <= 1'b0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            dec_q     <= 4'(CAPACITY / 10);
            uni_q     <= 4'(CAPACITY % 10);
            rechazo_q <= 1'b0;
            error_q   <= 1'b0;
            state_q   <= CERRADA;
            timer_q   <= '0;
        end else begin
            entrada_q <= bus.entrada;
            salida_q  <= bus.salida;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            dec_q     <= dec_d;
            uni_q     <= uni_d;
            rechazo_q <= rechazo_d;
            error_q   <= error_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.libres_dec = dec_q;
    assign bus.libres_uni = uni_q;
    assign bus.rechazo    = rechazo_q;
    assign bus.error      = error_q;
    assign bus.barrera    = (state_q == ABIERTA);

endmodule

// File: tb/tb_parking_occupancy.sv
// Directed bench: a small lot (CAPACITY=3, GATE_CYCLES=4) plus a default-sized
// instance for the two-digit free-space display.
module tb_parking_occupancy;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    parking_occupancy_if #(.CNT_W(3)) bus_a ();
    parking_occupancy_if #(.CNT_W(7)) bus_b ();

    parking_occupancy #(
        .CAPACITY(3), .CNT_W(3), .GATE_CYCLES(4), .TMR_W(2)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave)
    );

    parking_occupancy #(
        .CAPACITY(20), .CNT_W(7), .GATE_CYCLES(50), .TMR_W(6)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_total++;
        assert (obs === 32'(exp))
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        bus_a.entrada = 1'b0;
        bus_a.salida  = 1'b0;
        bus_b.entrada = 1'b0;
        bus_b.salida  = 1'b0;

        // reset state
        #12;
        chk("rst_count",   32'(bus_a.count), 0);
        chk("rst_empty",   32'(bus_a.empty), 1);
        chk("rst_full",    32'(bus_a.full), 0);
        chk("rst_dec",     32'(bus_a.libres_dec), 0);
        chk("rst_uni",     32'(bus_a.libres_uni), 3);
        chk("rst_barrera", 32'(bus_a.barrera), 0);
        chk("rst_error",   32'(bus_a.error), 0);
        chk("rst_rechazo", 32'(bus_a.rechazo), 0);
        chk("rst_b_dec",   32'(bus_b.libres_dec), 2);
        chk("rst_b_uni",   32'(bus_b.libres_uni), 0);
        reset = 1'b1;

        // three entries, each held 3 cycles
        bus_a.entrada = 1'b1; tick();
        chk("in1_count",   32'(bus_a.count), 1);
        chk("in1_empty",   32'(bus_a.empty), 0);
        chk("in1_barrera", 32'(bus_a.barrera), 1);
        tick(); tick();
        chk("in1_held",    32'(bus_a.count), 1);
        bus_a.entrada = 1'b0; tick();
        bus_a.entrada = 1'b1; tick();
        chk("in2_count",   32'(bus_a.count), 2);
        chk("in2_uni",     32'(bus_a.libres_uni), 1);
        tick(); tick();
        bus_a.entrada = 1'b0; tick();
        bus_a.entrada = 1'b1; tick();
        chk("in3_count",   32'(bus_a.count), 3);
        chk("in3_full",    32'(bus_a.full), 1);
        chk("in3_uni",     32'(bus_a.libres_uni), 0);
        tick(); tick();
        bus_a.entrada = 1'b0; tick();
        tick(); tick(); tick();
        chk("in3_closed",  32'(bus_a.barrera), 0);

        // entry while full is rejected
        bus_a.entrada = 1'b1; tick();
        chk("rej_count",   32'(bus_a.count), 3);
        chk("rej_pulse",   32'(bus_a.rechazo), 1);
        chk("rej_barrera", 32'(bus_a.barrera), 0);
        tick();
        chk("rej_drop",    32'(bus_a.rechazo), 0);
        bus_a.entrada = 1'b0; tick();

        // one exit, then let the window close
        bus_a.salida = 1'b1; tick();
        chk("out_count",   32'(bus_a.count), 2);
        chk("out_full",    32'(bus_a.full), 0);
        chk("out_uni",     32'(bus_a.libres_uni), 1);
        bus_a.salida = 1'b0; tick();
        tick(); tick(); tick(); tick();
        chk("out_closed",  32'(bus_a.barrera), 0);

        // simultaneous entry and exit
        bus_a.entrada = 1'b1; bus_a.salida = 1'b1; tick();
        chk("sim_count",   32'(bus_a.count), 2);
        chk("sim_barrera", 32'(bus_a.barrera), 1);
        chk("sim_rechazo", 32'(bus_a.rechazo), 0);
        chk("sim_error",   32'(bus_a.error), 0);
        bus_a.entrada = 1'b0; bus_a.salida = 1'b0; tick();

        // drain to empty, then exit while empty
        bus_a.salida = 1'b1; tick();
        chk("drain1",      32'(bus_a.count), 1);
        bus_a.salida = 1'b0; tick();
        bus_a.salida = 1'b1; tick();
        chk("drain0",      32'(bus_a.count), 0);
        chk("drain_empty", 32'(bus_a.empty), 1);
        bus_a.salida = 1'b0; tick();
        bus_a.salida = 1'b1; tick();
        chk("err_count",   32'(bus_a.count), 0);
        chk("err_set",     32'(bus_a.error), 1);
        bus_a.salida = 1'b0; tick();
        bus_a.entrada = 1'b1; tick();
        chk("err_in_cnt",  32'(bus_a.count), 1);
        chk("err_sticky",  32'(bus_a.error), 1);
        bus_a.entrada = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("pre_gate",    32'(bus_a.barrera), 0);

        // single isolated entry: open exactly four cycles
        bus_a.entrada = 1'b1; tick();
        chk("gate_c1",     32'(bus_a.barrera), 1);
        bus_a.entrada = 1'b0; tick();
        chk("gate_c2",     32'(bus_a.barrera), 1);
        tick();
        chk("gate_c3",     32'(bus_a.barrera), 1);
        tick();
        chk("gate_c4",     32'(bus_a.barrera), 1);
        tick();
        chk("gate_shut",   32'(bus_a.barrera), 0);
        chk("gate_count",  32'(bus_a.count), 2);

        // window extended by an event sampled at the end of the third open cycle
        bus_a.salida = 1'b1; tick();
        chk("ext_open",    32'(bus_a.barrera), 1);
        bus_a.salida = 1'b0; tick();
        tick();
        bus_a.entrada = 1'b1; tick();
        chk("ext_c1",      32'(bus_a.barrera), 1);
        chk("ext_count",   32'(bus_a.count), 2);
        bus_a.entrada = 1'b0; tick();
        chk("ext_c2",      32'(bus_a.barrera), 1);
        tick();
        chk("ext_c3",      32'(bus_a.barrera), 1);
        tick();
        chk("ext_c4",      32'(bus_a.barrera), 1);
        tick();
        chk("ext_shut",    32'(bus_a.barrera), 0);

        // asynchronous reset in the middle of an open window
        bus_a.salida = 1'b1; tick();
        chk("mid_open",    32'(bus_a.barrera), 1);
        chk("mid_count",   32'(bus_a.count), 1);
        bus_a.salida = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("mid_barrera", 32'(bus_a.barrera), 0);
        chk("mid_rcount",  32'(bus_a.count), 0);
        chk("mid_error",   32'(bus_a.error), 0);
        chk("mid_uni",     32'(bus_a.libres_uni), 3);

        // input already high at release counts once
        bus_a.entrada = 1'b1;
        #3 reset = 1'b1;
        bus_b.entrada = 1'b1;
        tick();
        chk("rel_count",   32'(bus_a.count), 1);
        chk("rel_b_count", 32'(bus_b.count), 1);
        chk("rel_b_dec",   32'(bus_b.libres_dec), 1);
        chk("rel_b_uni",   32'(bus_b.libres_uni), 9);
        chk("rel_b_gate",  32'(bus_b.barrera), 1);
        tick();
        chk("rel_held",    32'(bus_a.count), 1);
        bus_a.entrada = 1'b0;
        bus_b.entrada = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
